// File: rtl/palette_pkg.sv
// Shared types and reset contents for the palette/fade pixel stage.
package palette_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    OUT  = 2'b01,
    IN   = 2'b10,
    RSVD = 2'b11
  } fade_cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    FADE_OUT = 2'b01,
    FADE_IN  = 2'b10
  } fade_state_t;

  // Text-mode colours, {R,G,B} at 4 bits per channel.
  localparam logic [11:0] DEFAULT_PALETTE [16] = '{
    12'h256, 12'hACD, 12'h0A0, 12'hEC3,
    12'h00A, 12'hA0A, 12'h0AA, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'hB12,
    12'hF55, 12'hF5F, 12'hFF5, 12'h835
  };

  // Reset value of any palette slot; slots past the table start black.
  function automatic logic [11:0] default_entry(input int i);
    if (i >= 0 && i < 16) return DEFAULT_PALETTE[i[3:0]];
    return 12'h000;
  endfunction

endpackage

// File: rtl/palette_fade_ctrl.sv
// Frame-paced brightness fade engine: FSM, per-level frame counter and level register.
module palette_fade_ctrl
  import palette_pkg::*;
#(
  parameter int FADE_W = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              fade_start,
  input  logic [1:0]        fade_cmd,
  input  logic [3:0]        fade_frames,
  output logic              fade_busy,
  output logic              fade_done,
  output logic [FADE_W:0]   fade_level,
  output fade_state_t       fade_state
);

  localparam logic [FADE_W:0] FULL = {1'b1, {FADE_W{1'b0}}};
  localparam logic [FADE_W:0] ONE  = {{FADE_W{1'b0}}, 1'b1};

  fade_state_t       state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [FADE_W:0]   level, level_n;
  logic              done, done_n;
  logic [3:0]        last_cnt;

  // A programmed step length of 0 behaves as 1 frame per level.
  assign last_cnt = (fade_frames == 4'd0) ? 4'd0 : fade_frames - 4'd1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      level <= FULL;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fade_start && fade_cmd == OUT) begin
          state_n = FADE_OUT;
          cnt_n   = 4'd0;
        end else if (fade_start && fade_cmd == IN) begin
          state_n = FADE_IN;
          cnt_n   = 4'd0;
        end
      end
      FADE_OUT: begin
        if (frame_start) begin
          // Already black: finish on this frame without touching the level.
          if (level == '0) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            done_n  = 1'b1;
          end else if (cnt == last_cnt) begin
            cnt_n   = 4'd0;
            level_n = level - ONE;
            if (level == ONE) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      FADE_IN: begin
        if (frame_start) begin
          if (level == FULL) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            done_n  = 1'b1;
          end else if (cnt == last_cnt) begin
            cnt_n   = 4'd0;
            level_n = level + ONE;
            if (level == FULL - ONE) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  assign fade_busy  = (state != IDLE);
  assign fade_done  = done;
  assign fade_level = level;
  assign fade_state = state;

endmodule

// File: rtl/palette_fade_lut.sv
// Writable colour palette with a fixed 2-cycle index->RGB pipeline, brightness fade and transparency flag.
module palette_fade_lut
  import palette_pkg::*;
#(
  parameter int INDEX_W = 4,
  parameter int CH_W    = 4,
  parameter int FADE_W  = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                rd_valid,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                out_valid,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                out_transparent,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0]   wr_data,
  input  logic                transp_en,
  input  logic [INDEX_W-1:0]  transp_index,
  input  logic                frame_start,
  input  logic                fade_start,
  input  logic [1:0]          fade_cmd,
  input  logic [3:0]          fade_frames,
  output logic                fade_busy,
  output logic                fade_done,
  output logic [FADE_W:0]     fade_level,
  output fade_state_t         fade_state
);

  localparam int PAL_W       = 3 * CH_W;
  localparam int NUM_ENTRIES = 2 ** INDEX_W;

  logic [PAL_W-1:0] pal [NUM_ENTRIES];
  logic [PAL_W-1:0] s1_color;
  logic             s1_valid;
  logic             s1_transp;

  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                            input logic [FADE_W:0] lvl);
    logic [CH_W+FADE_W:0] prod;
    prod  = {{(FADE_W+1){1'b0}}, c} * {{CH_W{1'b0}}, lvl};
    scale = prod[FADE_W +: CH_W];
  endfunction

  palette_fade_ctrl #(.FADE_W(FADE_W)) u_ctrl (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .fade_start  (fade_start),
    .fade_cmd    (fade_cmd),
    .fade_frames (fade_frames),
    .fade_busy   (fade_busy),
    .fade_done   (fade_done),
    .fade_level  (fade_level),
    .fade_state  (fade_state)
  );

  // Flop-based storage so reset can restore the default colours.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) pal[i] <= PAL_W'(default_entry(i));
    end else if (wr_en) begin
      pal[wr_index] <= wr_data;
    end
  end

  // S1 samples the array before a same-edge write lands, giving read-old semantics.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_color  <= '0;
      s1_valid  <= 1'b0;
      s1_transp <= 1'b0;
    end else begin
      s1_color  <= pal[rd_index];
      s1_valid  <= rd_valid;
      s1_transp <= transp_en && (rd_index == transp_index);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid       <= 1'b0;
      red             <= '0;
      green           <= '0;
      blue            <= '0;
      out_transparent <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        red             <= scale(s1_color[3*CH_W-1 -: CH_W], fade_level);
        green           <= scale(s1_color[2*CH_W-1 -: CH_W], fade_level);
        blue            <= scale(s1_color[CH_W-1:0], fade_level);
        out_transparent <= s1_transp;
      end
    end
  end

endmodule

// File: tb/tb_palette_fade_lut.sv
// Scoreboard bench for palette_fade_lut: random pixel traffic against a palette/fade reference model.
module tb_palette_fade_lut;
  import palette_pkg::*;

  localparam int INDEX_W = 4;
  localparam int CH_W    = 4;
  localparam int FADE_W  = 4;
  localparam int W       = 3 * CH_W + 1;

  logic               Clk;
  logic               Reset_n;
  logic               rd_valid;
  logic [INDEX_W-1:0] rd_index;
  logic               out_valid;
  logic [CH_W-1:0]    red, green, blue;
  logic               out_transparent;
  logic               wr_en;
  logic [INDEX_W-1:0] wr_index;
  logic [3*CH_W-1:0]  wr_data;
  logic               transp_en;
  logic [INDEX_W-1:0] transp_index;
  logic               frame_start;
  logic               fade_start;
  logic [1:0]         fade_cmd;
  logic [3:0]         fade_frames;
  logic               fade_busy;
  logic               fade_done;
  logic [FADE_W:0]    fade_level;
  fade_state_t        fade_state;

  palette_fade_lut #(.INDEX_W(INDEX_W), .CH_W(CH_W), .FADE_W(FADE_W)) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .rd_valid        (rd_valid),
    .rd_index        (rd_index),
    .out_valid       (out_valid),
    .red             (red),
    .green           (green),
    .blue            (blue),
    .out_transparent (out_transparent),
    .wr_en           (wr_en),
    .wr_index        (wr_index),
    .wr_data         (wr_data),
    .transp_en       (transp_en),
    .transp_index    (transp_index),
    .frame_start     (frame_start),
    .fade_start      (fade_start),
    .fade_cmd        (fade_cmd),
    .fade_frames     (fade_frames),
    .fade_busy       (fade_busy),
    .fade_done       (fade_done),
    .fade_level      (fade_level),
    .fade_state      (fade_state)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Scoreboard state and reference model
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, want;
  int           checks, failures, done_pulses;
  logic [11:0]  mpal [16];
  int           mlevel;

  function automatic void load_defaults();
    mpal = '{12'h256, 12'hACD, 12'h0A0, 12'hEC3, 12'h00A, 12'hA0A, 12'h0AA, 12'hAAA,
             12'h555, 12'h55F, 12'h5F5, 12'hB12, 12'hF55, 12'hF5F, 12'hFF5, 12'h835};
  endfunction

  function automatic logic [W-1:0] model_px(input int idx);
    int r, g, b;
    logic t;
    r = (int'(mpal[idx][11:8]) * mlevel) / 16;
    g = (int'(mpal[idx][7:4])  * mlevel) / 16;
    b = (int'(mpal[idx][3:0])  * mlevel) / 16;
    t = transp_en && (idx == int'(transp_index));
    return {t, r[3:0], g[3:0], b[3:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, req);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input int idx, input bit do_wr, input int widx, input logic [11:0] wdata);
    exp_q.push_back(model_px(idx));
    rd_valid = 1'b1;
    rd_index = idx[INDEX_W-1:0];
    wr_en    = do_wr;
    wr_index = widx[INDEX_W-1:0];
    wr_data  = wdata;
    if (do_wr) mpal[widx] = wdata;
    step();
    rd_valid = 1'b0;
    wr_en    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
  endtask

  task automatic start_fade(input logic [1:0] cmd);
    fade_start = 1'b1;
    fade_cmd   = cmd;
    step();
    fade_start = 1'b0;
  endtask

  // Monitor: pops one expectation per valid output pixel
  always @(negedge Clk) begin
    if (fade_done) done_pulses++;
    if (Reset_n && out_valid) begin
      checks++;
      got = {out_transparent, red, green, blue};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL px_unexpected got=%h want=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL px got=%h want=%h", got, want);
        end
      end
    end
  end

  initial begin
    checks = 0; failures = 0; done_pulses = 0;
    load_defaults();
    mlevel = 16;
    Reset_n = 1'b0; rd_valid = 1'b0; rd_index = '0; wr_en = 1'b0; wr_index = '0;
    wr_data = '0; transp_en = 1'b0; transp_index = '0; frame_start = 1'b0;
    fade_start = 1'b0; fade_cmd = 2'b00; fade_frames = 4'd1;
    repeat (3) step();

    chk("rst_out_valid", out_valid, 0);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_transp", out_transparent, 0);
    chk("rst_level", fade_level, 16);
    chk("rst_busy", fade_busy, 0);
    chk("rst_done", fade_done, 0);
    chk("rst_state", fade_state, IDLE);
    Reset_n = 1'b1;
    step();

    // Default colours
    issue(0, 0, 0, 0); issue(1, 0, 0, 0); issue(11, 0, 0, 0);
    drain();
    chk("level_full", fade_level, 16);

    // Same-cycle write/read returns old, next read returns new
    issue(3, 1, 3, 12'hFFF);
    issue(3, 0, 0, 0);
    drain();

    // Transparency
    transp_en = 1'b1; transp_index = 0;
    issue(0, 0, 0, 0); issue(1, 0, 0, 0);
    drain();

    // Random traffic; writes kept off entries 0..3
    for (int n = 0; n < 40; n++) begin
      transp_en    = ($urandom_range(0, 1) == 1);
      transp_index = INDEX_W'($urandom_range(0, 15));
      issue($urandom_range(0, 15), ($urandom_range(0, 2) == 0),
            $urandom_range(4, 15), 12'($urandom_range(0, 4095)));
    end
    drain();
    transp_en = 1'b0;

    // Reserved and no-op commands are ignored
    start_fade(2'b11); chk("cmd11_ignored", fade_busy, 0);
    start_fade(2'b00); chk("cmd00_ignored", fade_busy, 0);

    // Fade out, 2 frames per level
    fade_frames = 4'd2;
    done_pulses = 0;
    start_fade(2'b01);
    chk("fo_busy", fade_busy, 1);
    chk("fo_level_start", fade_level, 16);
    for (int k = 1; k <= 32; k++) begin
      frame();
      mlevel = (16 - k / 2 < 0) ? 0 : 16 - k / 2;
      chk("fo_level", fade_level, mlevel);
      chk("fo_busy", fade_busy, (k < 32));
      if (k == 16) begin
        issue(1, 0, 0, 0);
        drain();
      end else if (k % 6 == 3) begin
        issue($urandom_range(0, 15), 0, 0, 0);
        drain();
      end
    end
    chk("fo_done_count", done_pulses, 1);

    // Fade in from black, step length 0 treated as 1; restart mid-fade ignored
    fade_frames = 4'd0;
    done_pulses = 0;
    start_fade(2'b10);
    for (int k = 1; k <= 16; k++) begin
      frame();
      mlevel = k;
      chk("fi_level", fade_level, mlevel);
      chk("fi_busy", fade_busy, (k < 16));
      if (k == 5) begin
        start_fade(2'b01);
        chk("fi_restart_ignored", fade_state, FADE_IN);
      end
      if (k == 7) begin
        issue($urandom_range(0, 15), 0, 0, 0);
        drain();
      end
    end
    chk("fi_done_count", done_pulses, 1);

    // Start and frame pulse together: that frame does not count
    fade_frames = 4'd1;
    fade_start = 1'b1; fade_cmd = 2'b01; frame_start = 1'b1;
    step();
    fade_start = 1'b0; frame_start = 1'b0;
    chk("same_cycle_level", fade_level, 16);
    chk("same_cycle_busy", fade_busy, 1);
    for (int k = 1; k <= 11; k++) frame();
    chk("fo_level5", fade_level, 5);

    // Reset mid-fade with a pixel in flight
    wr_en = 1'b1; wr_index = 0; wr_data = 12'h000;
    step();
    wr_en = 1'b0;
    rd_valid = 1'b1; rd_index = 0;
    step();
    rd_valid = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_level", fade_level, 16);
    chk("mid_rst_busy", fade_busy, 0);
    chk("mid_rst_state", fade_state, IDLE);
    step();
    Reset_n = 1'b1;
    load_defaults();
    mlevel = 16;
    step();
    chk("mid_rst_no_pixel", out_valid, 0);
    issue(0, 0, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
